joker_reset_seq: RTL and testbench

Parametrised power/reset sequencer for the Joker TV front-end rails and resets: tuner, demods, CI power, antenna 5V and I2C gate.
- Generates the board power-on reset and a 1 us timebase.
- Drives NUM_CH enable/reset lines with per-channel output polarity.
- Releases channels one at a time with a programmable stagger; disables them immediately.
- Suspend forces every channel to its disabled level.
- Sits in the top level between joker_control's reset_ctrl register and the board pins, and replaces the ad-hoc reset counter and suspend gating assigns.

---
 rtl/joker_pkg.sv | 21 ++
 rtl/joker_us_timebase.sv | 31 +++
 rtl/joker_reset_seq.sv | 115 +++++++++++
 tb/tb_joker_reset_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/joker_pkg.sv
// Shared definitions for the Joker TV power/reset sequencer and its helpers.
package joker_pkg;

    typedef enum logic [1:0] {
        StPor,
        StIdle,
        StWait
    } state_e;

    localparam int unsigned DEF_CLKS_PER_US = 50;
    localparam logic [7:0]  DEF_OUT_INV     = 8'h8F;

    // Widest channel vector the priority encoder handles.
    localparam int unsigned MAX_CH = 32;

    // One-hot of the lowest set bit (zero in, zero out).
    function automatic logic [MAX_CH-1:0] lowest_set(input logic [MAX_CH-1:0] v);
        return v & (-v);
    endfunction

endpackage

// File: rtl/joker_us_timebase.sv
// Free-running prescaler: one-cycle pulse_1us every CLKS_PER_US clocks.
module joker_us_timebase #(
    parameter int unsigned CLKS_PER_US = 50
) (
    input  logic clk,
    input  logic reset_n,
    output logic pulse_1us
);

    localparam int unsigned CntW = $clog2(CLKS_PER_US);

    logic [CntW-1:0] cnt_q;
    logic            pulse_q;

    // Count 0..CLKS_PER_US-1; the pulse is registered on the wrap.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else if (cnt_q == CntW'(CLKS_PER_US - 1)) begin
            cnt_q   <= '0;
            pulse_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_q + CntW'(1);
            pulse_q <= 1'b0;
        end
    end

    assign pulse_1us = pulse_q;

endmodule

// File: rtl/joker_reset_seq.sv
// Power/reset sequencer: board POR, staggered channel release, immediate disable,
// suspend gating. NUM_CH must not exceed joker_pkg::MAX_CH.
module joker_reset_seq
    import joker_pkg::*;
#(
    parameter int unsigned       CLKS_PER_US = DEF_CLKS_PER_US,
    parameter int unsigned       NUM_CH      = 8,
    parameter logic [NUM_CH-1:0] OUT_INV     = DEF_OUT_INV,
    parameter int unsigned       POR_US      = 1000000,
    parameter int unsigned       STAGGER_US  = 1000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              suspend,
    input  logic [NUM_CH-1:0] ctrl_req,
    output logic [NUM_CH-1:0] ch_out,
    output logic [NUM_CH-1:0] ch_en,
    output logic              por_reset,
    output logic              por_done,
    output logic              pulse_1us,
    output logic              busy
);

    localparam int unsigned PorW = (POR_US > 0) ? $clog2(POR_US + 1) : 1;
    localparam int unsigned StgW = (STAGGER_US > 0) ? $clog2(STAGGER_US + 1) : 1;

    state_e            state_q;
    logic [PorW-1:0]   us_cnt_q;
    logic [StgW-1:0]   stag_q;
    logic [NUM_CH-1:0] ch_en_q, ch_en_d, ch_out_q;
    logic [NUM_CH-1:0] req_en, pend, rel_bit;
    logic              por_reset_q, por_done_q, busy_q;
    logic              pulse;
    logic              por_hit;

    joker_us_timebase #(
        .CLKS_PER_US (CLKS_PER_US)
    ) u_timebase (
        .clk       (clk),
        .reset_n   (reset_n),
        .pulse_1us (pulse)
    );

    // Disable mask applies every cycle; a release only ever adds a bit from req_en.
    always_comb begin
        req_en  = ~ctrl_req & {NUM_CH{~suspend & por_done_q}};
        pend    = req_en & ~ch_en_q;
        rel_bit = NUM_CH'(lowest_set(MAX_CH'(pend)));
        ch_en_d = ch_en_q & req_en;
        if (state_q == StIdle) begin
            ch_en_d = ch_en_d | rel_bit;
        end
        // True on the pulse that brings the us count to POR_US (first pulse if POR_US=0).
        por_hit = (32'(us_cnt_q) + 32'd1) >= POR_US;
    end

    // Sequencer FSM with registered pin and status outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StPor;
            us_cnt_q    <= '0;
            stag_q      <= '0;
            ch_en_q     <= '0;
            ch_out_q    <= ~OUT_INV;
            por_reset_q <= 1'b1;
            por_done_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ch_en_q  <= ch_en_d;
            ch_out_q <= ch_en_d ^ ~OUT_INV;
            unique case (state_q)
                StPor: begin
                    if (pulse) begin
                        // Saturates at POR_US; never wraps after expiry.
                        if (32'(us_cnt_q) < POR_US) begin
                            us_cnt_q <= us_cnt_q + PorW'(1);
                        end
                        if (por_hit) begin
                            state_q     <= StIdle;
                            por_reset_q <= 1'b0;
                            por_done_q  <= 1'b1;
                        end
                    end
                end
                StIdle: begin
                    if (pend != '0) begin
                        state_q <= StWait;
                        stag_q  <= StgW'(STAGGER_US);
                        busy_q  <= 1'b1;
                    end
                end
                StWait: begin
                    // Runs to completion even if channels are dropped meanwhile.
                    if (pulse) begin
                        if (stag_q == '0) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end else begin
                            stag_q <= stag_q - StgW'(1);
                        end
                    end
                end
                default: state_q <= StPor;
            endcase
        end
    end

    assign ch_en     = ch_en_q;
    assign ch_out    = ch_out_q;
    assign por_reset = por_reset_q;
    assign por_done  = por_done_q;
    assign pulse_1us = pulse;
    assign busy      = busy_q;

endmodule

// File: tb/tb_joker_reset_seq.sv
// Bench for joker_reset_seq: directed vector table, release-order sequence,
// and randomized stimulus against a timestamp-based reference model.
module tb_joker_reset_seq;

    localparam int unsigned CPU     = 4;
    localparam int unsigned NCH     = 8;
    localparam int unsigned POR     = 10;
    localparam int unsigned STG     = 3;
    localparam logic [7:0]  INV     = 8'h8F;
    localparam int          PorEdge = CPU * ((POR == 0) ? 1 : POR) + 1;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       suspend;
    logic [7:0] ctrl_req;
    logic [7:0] ch_out, ch_en;
    logic       por_reset, por_done, pulse_1us, busy;

    always #5 clk = ~clk;

    joker_reset_seq #(
        .CLKS_PER_US (CPU),
        .NUM_CH      (NCH),
        .OUT_INV     (INV),
        .POR_US      (POR),
        .STAGGER_US  (STG)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .suspend   (suspend),
        .ctrl_req  (ctrl_req),
        .ch_out    (ch_out),
        .ch_en     (ch_en),
        .por_reset (por_reset),
        .por_done  (por_done),
        .pulse_1us (pulse_1us),
        .busy      (busy)
    );

    int errors = 0;
    int checks = 0;

    // Model state: edges since reset release, enables, last release edge and
    // the edge on which that release's stagger interval ends.
    int         t   = 0;
    int         m_e = 0;
    int         m_x = 0;
    logic [7:0] m_en = 8'h00;

    typedef struct {
        int         cycles;
        logic       rst_n;
        logic       susp;
        logic [7:0] ctrl;
        logic [7:0] en;
        logic [7:0] out;
        logic       por;
        logic       bsy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int c, logic r, logic s, logic [7:0] q, logic [7:0] e,
                                logic [7:0] o, logic p, logic b);
        vec_t v;
        v.cycles = c; v.rst_n = r; v.susp = s; v.ctrl = q;
        v.en = e; v.out = o; v.por = p; v.bsy = b;
        return v;
    endfunction

    function automatic logic [7:0] lowbit(logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return 8'(1 << i);
        end
        return 8'h00;
    endfunction

    // Advance the model by one clock edge using the inputs sampled at that edge.
    task automatic model_edge();
        logic [7:0] req, pend;
        logic       pd_before;
        int         first;
        if (!reset_n) begin
            t = 0; m_en = 8'h00; m_e = 0; m_x = 0;
            return;
        end
        t++;
        pd_before = (t - 1) >= PorEdge;
        req  = ~ctrl_req & {8{~suspend & pd_before}};
        pend = req & ~m_en;
        m_en = m_en & req;
        // Idle once the previous stagger interval has ended.
        if (pd_before && t >= m_x + 1 && pend != 8'h00) begin
            m_en  = m_en | lowbit(pend);
            m_e   = t;
            first = ((t - 1) / CPU + 1) * CPU + 1;
            m_x   = first + CPU * STG;
        end
    endtask

    task automatic check_model();
        logic [13:0] exp_v, act_v;
        logic        e_pulse, e_done, e_busy;
        e_pulse = (t > 0) && (t % CPU == 0);
        e_done  = t >= PorEdge;
        e_busy  = (m_x != 0) && (t >= m_e) && (t < m_x);
        exp_v = {m_en, m_en ^ ~INV, 1'b0, e_done, e_pulse, e_busy};
        exp_v[3] = ~e_done;
        act_v = {ch_en, ch_out, por_reset, por_done, pulse_1us, busy};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL model t=%0d: en/out/por/done/pulse/busy got %h/%h/%b/%b/%b/%b want %h/%h/%b/%b/%b/%b",
                     t, ch_en, ch_out, por_reset, por_done, pulse_1us, busy,
                     exp_v[13:6], exp_v[5:0] >> 4 | exp_v[13:6] ^ ~INV, exp_v[3], exp_v[2],
                     exp_v[1], exp_v[0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    initial begin
        logic [7:0] prev;
        logic [7:0] exp_en;
        int         nidx;
        int         last_rel;
        bit         done;

        reset_n  = 1'b0;
        suspend  = 1'b0;
        ctrl_req = 8'hFF;

        // Directed table: t values in comments are edges since reset release.
        vecs.push_back(mk( 2, 0, 0, 8'hFF, 8'h00, 8'h70, 1, 0)); // reset
        vecs.push_back(mk(41, 1, 0, 8'hF3, 8'h00, 8'h70, 0, 0)); // t=41 POR done
        vecs.push_back(mk( 1, 1, 0, 8'hF3, 8'h04, 8'h74, 0, 1)); // t=42 bit2
        vecs.push_back(mk(15, 1, 0, 8'hF3, 8'h04, 8'h74, 0, 0)); // t=57 stagger end
        vecs.push_back(mk( 1, 1, 0, 8'hF3, 8'h0C, 8'h7C, 0, 1)); // t=58 bit3
        vecs.push_back(mk( 1, 1, 1, 8'hF3, 8'h00, 8'h70, 0, 1)); // t=59 suspend
        vecs.push_back(mk(13, 1, 1, 8'hF3, 8'h00, 8'h70, 0, 1)); // t=72 timer runs on
        vecs.push_back(mk( 1, 1, 1, 8'hF3, 8'h00, 8'h70, 0, 0)); // t=73
        vecs.push_back(mk( 1, 1, 0, 8'hF3, 8'h04, 8'h74, 0, 1)); // t=74 bit2 again
        vecs.push_back(mk(15, 1, 0, 8'hF3, 8'h04, 8'h74, 0, 0)); // t=89
        vecs.push_back(mk( 1, 1, 0, 8'hF3, 8'h0C, 8'h7C, 0, 1)); // t=90 bit3
        vecs.push_back(mk( 1, 1, 0, 8'h00, 8'h0C, 8'h7C, 0, 1)); // t=91 no release in WAIT
        vecs.push_back(mk( 1, 1, 0, 8'hFF, 8'h00, 8'h70, 0, 1)); // t=92 disable
        vecs.push_back(mk(12, 1, 0, 8'hFF, 8'h00, 8'h70, 0, 1)); // t=104
        vecs.push_back(mk( 1, 1, 0, 8'hFF, 8'h00, 8'h70, 0, 0)); // t=105
        vecs.push_back(mk( 3, 1, 0, 8'hFF, 8'h00, 8'h70, 0, 0)); // t=108
        vecs.push_back(mk( 1, 1, 0, 8'hF3, 8'h04, 8'h74, 0, 1)); // t=109
        vecs.push_back(mk(17, 1, 0, 8'hF3, 8'h0C, 8'h7C, 0, 1)); // t=126
        vecs.push_back(mk( 1, 0, 0, 8'hF3, 8'h00, 8'h70, 1, 0)); // mid-run reset
        vecs.push_back(mk(40, 1, 0, 8'hF3, 8'h00, 8'h70, 1, 0)); // t=40
        vecs.push_back(mk( 1, 1, 0, 8'hF3, 8'h00, 8'h70, 0, 0)); // t=41
        vecs.push_back(mk( 1, 1, 0, 8'hF3, 8'h04, 8'h74, 0, 1)); // t=42
        vecs.push_back(mk( 1, 1, 1, 8'hF3, 8'h00, 8'h70, 0, 1)); // suspend

        foreach (vecs[i]) begin
            reset_n  = vecs[i].rst_n;
            suspend  = vecs[i].susp;
            ctrl_req = vecs[i].ctrl;
            for (int c = 0; c < vecs[i].cycles; c++) step();
            checks++;
            if (ch_en !== vecs[i].en || ch_out !== vecs[i].out ||
                por_reset !== vecs[i].por || busy !== vecs[i].bsy) begin
                errors++;
                $display("FAIL vec%0d: en=%h out=%h por=%b busy=%b, want en=%h out=%h por=%b busy=%b",
                         i, ch_en, ch_out, por_reset, busy,
                         vecs[i].en, vecs[i].out, vecs[i].por, vecs[i].bsy);
            end
        end

        // All channels requested from reset: releases in index order, spaced apart.
        reset_n  = 1'b0;
        suspend  = 1'b0;
        ctrl_req = 8'h00;
        step();
        step();
        reset_n  = 1'b1;
        nidx     = 0;
        last_rel = 0;
        done     = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            prev = ch_en;
            step();
            if (ch_en != prev) begin
                exp_en = prev | (8'h01 << nidx);
                checks++;
                if (ch_en !== exp_en) begin
                    errors++;
                    $display("FAIL order: en=%h want %h", ch_en, exp_en);
                end
                if (nidx > 0) begin
                    checks++;
                    if (t - last_rel < int'(STG * CPU)) begin
                        errors++;
                        $display("FAIL spacing bit%0d: %0d cycles, want >= %0d",
                                 nidx, t - last_rel, STG * CPU);
                    end
                end
                last_rel = t;
                nidx++;
                if (ch_en == 8'hFF) done = 1'b1;
            end
        end
        checks++;
        if (!done || ch_out !== 8'h8F) begin
            errors++;
            $display("FAIL all_on: done=%b out=%h, want done=1 out=8f", done, ch_out);
        end

        // Randomized stimulus against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 19) == 0) begin
                ctrl_req = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            end
            if ($urandom_range(0, 59) == 0) suspend = ~suspend;
            reset_n = ($urandom_range(0, 799) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
